// File: rtl/counter_ctrl.sv
// counter_ctrl: two-requester round-robin controller that steps a counter toward a latched target.
// Optional macro COUNTER_CTRL_SHORTEST_PATH_EN selects wrap-aware (shortest path) direction choice.
module counter_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_target,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_target,
  output logic             req1_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] counter_out,
  output logic             cnt_enable,
  output logic             cnt_direction,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  localparam int unsigned   PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MOVE = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             id_q, id_d;
  logic             rr_q, rr_d;
  logic             dir_q, dir_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             busy_q, busy_d;

  logic             grant_any_s;
  logic             grant_id_s;
  logic             up_s;
  logic [WIDTH-1:0] step_s;

  // Round-robin pick: rr_q holds the last granted requester, so a tie goes to the other one.
  always_comb begin
    grant_any_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~rr_q;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Ready is gated by rst so it stays low while reset is held.
  assign req0_ready = rst && (state_q == IDLE) && grant_any_s && !grant_id_s;
  assign req1_ready = rst && (state_q == IDLE) && grant_any_s &&  grant_id_s;

`ifdef COUNTER_CTRL_SHORTEST_PATH_EN
  localparam logic [WIDTH:0] HALF = {2'b01, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] diff_s;

  // Forward distance modulo 2^WIDTH; go up when it is at most half the ring.
  always_comb begin
    diff_s = target_q - count_q;
    up_s   = ({1'b0, diff_s} <= HALF);
  end
`else
  // Without wrap-aware choice the move never crosses the 0 / max boundary.
  always_comb begin
    up_s = (target_q > count_q);
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    pre_d     = pre_q;
    id_d      = id_q;
    rr_d      = rr_q;
    dir_d     = dir_q;
    enable_d  = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    step_s    = dir_q ? (count_q + {{(WIDTH-1){1'b0}}, 1'b1})
                      : (count_q - {{(WIDTH-1){1'b0}}, 1'b1});
    case (state_q)
      IDLE: begin
        if (grant_any_s) begin
          state_d  = LOAD;
          target_d = grant_id_s ? req1_target : req0_target;
          id_d     = grant_id_s;
          rr_d     = grant_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (target_q == count_q) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          state_d = MOVE;
          dir_d   = up_s;
          pre_d   = {PW{1'b0}};
        end
      end
      MOVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pre_q == PRE_LAST) begin
          pre_d    = {PW{1'b0}};
          count_d  = step_s;
          enable_d = 1'b1;
          if (step_s == target_q) begin
            state_d   = DONE;
            done_d    = 1'b1;
            done_id_d = id_q;
          end else begin
            state_d = MOVE;
          end
        end else begin
          pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; requester 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= {WIDTH{1'b0}};
      target_q  <= {WIDTH{1'b0}};
      pre_q     <= {PW{1'b0}};
      id_q      <= 1'b0;
      rr_q      <= 1'b1;
      dir_q     <= 1'b0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      pre_q     <= pre_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      dir_q     <= dir_d;
      enable_q  <= enable_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  assign counter_out   = count_q;
  assign cnt_enable    = enable_q;
  assign cnt_direction = dir_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_id       = done_id_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random moves checked against a
// transaction-level model of the expected path, step count and timing.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0v, r1v, ab;
  logic [7:0] r0t, r1t;
  logic       r0r, r1r, en, dir, busy, done, did;
  logic [7:0] cnt;

  logic       s0v, s1v, sab;
  logic [7:0] s0t, s1t;
  logic       s0r, s1r, sen, sdir, sbusy, sdone, sdid;
  logic [7:0] scnt;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] model_cnt;
  bit         model_rr;

  bit         w;
  bit         id_r;
  int         st, n_r, ab_at, dk, p1, p2, np;
  bit         up_r, seen;
  logic [7:0] t_r;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8), .STEP_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_target(r0t), .req0_ready(r0r),
    .req1_valid(r1v), .req1_target(r1t), .req1_ready(r1r),
    .abort(ab), .counter_out(cnt), .cnt_enable(en), .cnt_direction(dir),
    .busy(busy), .done(done), .done_id(did)
  );

  counter_ctrl #(.WIDTH(8), .STEP_DIV(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(s0v), .req0_target(s0t), .req0_ready(s0r),
    .req1_valid(s1v), .req1_target(s1t), .req1_ready(s1r),
    .abort(sab), .counter_out(scnt), .cnt_enable(sen), .cnt_direction(sdir),
    .busy(sbusy), .done(sdone), .done_id(sdid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected path of a move: number of unit steps and direction.
  function automatic void plan(input logic [7:0] from, input logic [7:0] to,
                               output int n, output bit up);
    logic [7:0] d;
    d = to - from;
`ifdef COUNTER_CTRL_SHORTEST_PATH_EN
    up = (int'(d) <= 128);
    n  = up ? int'(d) : 256 - int'(d);
`else
    up = (to > from);
    n  = up ? int'(to) - int'(from) : int'(from) - int'(to);
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; r0v = 1'b1; r1v = 1'b1; ab = 1'b0; s0v = 1'b0; s1v = 1'b0;
    #1;
    chk("rst_cnt",   32'(cnt),  32'd0);
    chk("rst_en",    32'(en),   32'd0);
    chk("rst_dir",   32'(dir),  32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_did",   32'(did),  32'd0);
    chk("rst_rdy0",  32'(r0r),  32'd0);
    chk("rst_rdy1",  32'(r1r),  32'd0);
    chk("rst_scnt",  32'(scnt), 32'd0);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0; rst = 1'b1;
    model_cnt = 8'd0; model_rr = 1'b1;
  endtask

  // Present requests in an IDLE cycle, check the grant, then withdraw the winner.
  task automatic present(input bit v0, input bit v1, input logic [7:0] t0,
                         input logic [7:0] t1, output bit winner);
    @(negedge clk);
    r0v = v0; r1v = v1; r0t = t0; r1t = t1;
    #1;
    winner = (v0 && v1) ? ~model_rr : v1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("grant_rdy0", 32'(r0r), 32'(winner == 1'b0));
    chk("grant_rdy1", 32'(r1r), 32'(winner == 1'b1));
    model_rr = winner;
    @(negedge clk);
    if (winner) r1v = 1'b0; else r0v = 1'b0;
  endtask

  // A request left waiting must be granted in the IDLE cycle that follows.
  task automatic pending(input bit id);
    @(negedge clk);
    #1;
    chk("pend_busy",  32'(busy), 32'd0);
    chk("pend_ready", 32'(id ? r1r : r0r), 32'd1);
    chk("pend_other", 32'(id ? r0r : r1r), 32'd0);
    model_rr = id;
    @(negedge clk);
    if (id) r1v = 1'b0; else r0v = 1'b0;
  endtask

  // Follow a granted move from its LOAD cycle (k = 1) until done or abort.
  task automatic run_to_done(input bit id, input logic [7:0] tgt, input int abort_at,
                             input string tag, output int steps);
    int n; bit up; bit fin; logic [7:0] start, e;
    plan(model_cnt, tgt, n, up);
    start = model_cnt; steps = 0; fin = 1'b0;
    for (int k = 1; k <= n + 8; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k == 1) begin
        chk({tag, "_rdy0_low"}, 32'(r0r), 32'd0);
        chk({tag, "_rdy1_low"}, 32'(r1r), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (en) begin
        steps++;
        e = up ? start + 8'(steps) : start - 8'(steps);
        chk({tag, "_step"}, 32'(cnt), 32'(e));
        chk({tag, "_dir"}, 32'(dir), 32'(up));
      end
      if (done) begin
        chk({tag, "_done_cycle"}, 32'(k), 32'(2 + n));
        chk({tag, "_done_id"}, 32'(did), 32'(id));
        chk({tag, "_steps"}, 32'(steps), 32'(n));
        chk({tag, "_final"}, 32'(cnt), 32'(tgt));
        model_cnt = tgt; fin = 1'b1;
        break;
      end
      if (k == abort_at) begin
        ab = 1'b1;
        @(posedge clk);
        #1;
        ab = 1'b0;
        e = (k == 1) ? start : (up ? start + 8'(k - 2) : start - 8'(k - 2));
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_done"}, 32'(done), 32'd0);
        chk({tag, "_abort_en"}, 32'(en), 32'd0);
        chk({tag, "_abort_hold"}, 32'(cnt), 32'(e));
        chk({tag, "_abort_steps"}, 32'(steps), 32'((k == 1) ? 0 : k - 2));
        model_cnt = e; fin = 1'b1;
        break;
      end
    end
    chk({tag, "_finished"}, 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b0; r0v = 1'b0; r1v = 1'b0; ab = 1'b0; r0t = 8'd0; r1t = 8'd0;
    s0v = 1'b0; s1v = 1'b0; sab = 1'b0; s0t = 8'd0; s1t = 8'd0;
    model_cnt = 8'd0; model_rr = 1'b1;

    do_reset();

    // Basic move to 5 from reset.
    present(1'b1, 1'b0, 8'd5, 8'd0, w);
    run_to_done(w, 8'd5, 0, "t5", st);

    // Target equal to current count 9: done two cycles after ready, no steps.
    present(1'b1, 1'b0, 8'd9, 8'd0, w);
    run_to_done(w, 8'd9, 0, "to9", st);
    present(1'b0, 1'b1, 8'd0, 8'd9, w);
    run_to_done(w, 8'd9, 0, "equal", st);
    chk("equal_steps", 32'(st), 32'd0);

    // Asynchronous reset in the middle of a move; the move must never complete.
    present(1'b1, 1'b0, 8'd30, 8'd0, w);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cnt",  32'(cnt),  32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_en",   32'(en),   32'd0);
    @(negedge clk);
    rst = 1'b1; model_cnt = 8'd0; model_rr = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    chk("mid_rst_hold",    32'(cnt),  32'd0);

    // Abort a move to 20 when the count shows 7.
    present(1'b1, 1'b0, 8'd20, 8'd0, w);
    run_to_done(w, 8'd20, 9, "abort7", st);
    chk("abort7_cnt", 32'(cnt), 32'd7);

    // Pointer advanced despite abort: tie goes to req1; abort on the target-reaching step.
    present(1'b1, 1'b1, 8'd12, 8'd9, w);
    run_to_done(w, 8'd9, 3, "abort_last", st);
    pending(1'b0);
    run_to_done(1'b0, 8'd12, 0, "pend12", st);

    // Tie at count 0 after reset: req0 (target 3) first, then req1 (target 1).
    do_reset();
    present(1'b1, 1'b1, 8'd3, 8'd1, w);
    chk("tie_first", 32'(w), 32'd0);
    run_to_done(w, 8'd3, 0, "tie0", st);
    pending(1'b1);
    run_to_done(1'b1, 8'd1, 0, "tie1", st);
    chk("tie_final", 32'(cnt), 32'd1);

    // Count 250 to target 4.
    present(1'b1, 1'b0, 8'd250, 8'd0, w);
    run_to_done(w, 8'd250, 0, "to250", st);
    present(1'b0, 1'b1, 8'd0, 8'd4, w);
    run_to_done(w, 8'd4, 0, "wrap", st);
`ifdef COUNTER_CTRL_SHORTEST_PATH_EN
    chk("wrap_steps", 32'(st), 32'd10);
`else
    chk("wrap_steps", 32'(st), 32'd246);
`endif

    // STEP_DIV = 3, 0 -> 2: MOVE entered at k = 2, pulses at k = 5 and k = 8.
    @(negedge clk);
    s0v = 1'b1; s0t = 8'd2;
    #1;
    chk("div3_ready",  32'(s0r), 32'd1);
    chk("div3_ready1", 32'(s1r), 32'd0);
    @(negedge clk);
    s0v = 1'b0;
    p1 = 0; p2 = 0; np = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (sen) begin
        np++;
        if (np == 1) p1 = k;
        if (np == 2) p2 = k;
        chk("div3_dir", 32'(sdir), 32'd1);
      end
      if (sdone) begin
        dk = k;
        chk("div3_did", 32'(sdid), 32'd0);
        chk("div3_busy", 32'(sbusy), 32'd1);
        break;
      end
    end
    chk("div3_pulses", 32'(np),   32'd2);
    chk("div3_first",  32'(p1),   32'd5);
    chk("div3_second", 32'(p2),   32'd8);
    chk("div3_done",   32'(dk),   32'd8);
    chk("div3_final",  32'(scnt), 32'd2);

    // Random moves, some aborted at a random cycle.
    for (int i = 0; i < 25; i++) begin
      id_r = 1'($urandom_range(0, 1));
      t_r  = 8'($urandom_range(0, 255));
      plan(model_cnt, t_r, n_r, up_r);
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 1 + n_r)) : 0;
      present(!id_r, id_r, t_r, t_r, w);
      run_to_done(w, t_r, ab_at, "rand", st);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and target width in bits.
REQ-002 SHALL have parameter STEP_DIV, default 1, range 1..255: clock cycles per counter step.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req0_valid  input  1  requester 0 presents a target.
REQ-006 SHALL have port req0_target  input  WIDTH  requester 0 target value.
REQ-007 SHALL have port req0_ready  output  1  requester 0 target accepted this cycle.
REQ-008 SHALL have ports req1_valid / req1_target / req1_ready, identical to the requester 0 ports, for requester 1.
REQ-009 SHALL have port abort  input  1  cancel the move in progress.
REQ-010 SHALL have port counter_out  output  WIDTH  current count value.
REQ-011 SHALL have port cnt_enable  output  1  high in each cycle in which counter_out steps.
REQ-012 SHALL have port cnt_direction  output  1  1 = up, 0 = down; the direction of the move in progress.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the target is reached.
REQ-015 SHALL have port done_id  output  1  identifies the requester that the done pulse belongs to.

Function
REQ-016 SHALL implement a four-state FSM with states IDLE, LOAD, MOVE and DONE.
REQ-017 In IDLE with any reqN_valid high, SHALL grant exactly one requester, assert its reqN_ready for that cycle only, and latch its target and ID.
REQ-018 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; after reset, requester 0 has priority.
REQ-019 SHALL keep reqN_ready low outside IDLE; requests presented in other states SHALL wait and SHALL NOT be dropped.
REQ-020 In LOAD, SHALL compute the direction, then enter MOVE; if target equals counter_out, SHALL enter DONE instead.
REQ-021 In MOVE, SHALL step counter_out by 1 in the latched direction once every STEP_DIV cycles, pulsing cnt_enable with each step.
REQ-022 The first step SHALL occur STEP_DIV cycles after entry to MOVE.
REQ-023 When counter_out equals the target after a step, SHALL enter DONE.
REQ-024 In DONE, SHALL assert done for one cycle with done_id equal to the latched ID, then return to IDLE.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH: 255+1 = 0 and 0-1 = 255 when WIDTH = 8.
REQ-026 abort high in LOAD or MOVE SHALL return the FSM to IDLE on the next edge.
REQ-027 On abort, counter_out SHALL hold its value, no done pulse SHALL be issued, and the round-robin pointer SHALL still advance.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 When abort coincides with a step that reaches the target, abort SHALL win: no step occurs and no done pulse is issued.
REQ-030 counter_out SHALL change only in MOVE.

Reset
REQ-031 While rst is low, SHALL hold the FSM in IDLE with counter_out = 0 and cnt_enable, cnt_direction, busy, done, done_id, req0_ready and req1_ready all 0.
REQ-032 Reset SHALL also clear the step prescaler and set the round-robin pointer so that requester 0 has priority.
REQ-033 Reset asserted mid-move SHALL take effect immediately (asynchronously), and the aborted request SHALL NOT be completed.

Configuration
REQ-034 Macro COUNTER_CTRL_SHORTEST_PATH_EN defined: SHALL compute d = (target - counter_out) mod 2^WIDTH and count up if d <= 2^(WIDTH-1), otherwise down; the move may wrap.
REQ-035 Macro COUNTER_CTRL_SHORTEST_PATH_EN undefined: SHALL count up if target > counter_out, otherwise down; the move never wraps.

Verification
REQ-036 Bench SHALL cover: reset, then req0 with target 5 and STEP_DIV = 1 -> ready for 1 cycle; 5 up-steps; done with done_id = 0; counter_out = 5.
REQ-037 Bench SHALL cover: req0 and req1 both valid at count 0, with targets 3 and 1 -> req0 served first, then req1; done_id sequence 0, 1; final counter_out = 1.
REQ-038 Bench SHALL cover: count 250, target 4 -> with the macro, 10 up-steps wrapping 255 to 0; without it, 246 down-steps.
REQ-039 Bench SHALL cover: STEP_DIV = 3, count 0, target 2 -> cnt_enable pulses exactly 3 and 6 cycles after MOVE entry.
REQ-040 Bench SHALL cover: abort during a move to 20, asserted at count 7 -> FSM in IDLE, counter_out holds 7, no done pulse, busy = 0.
REQ-041 Bench SHALL cover: target equal to current count 9 -> no cnt_enable pulse; done exactly 2 cycles after ready.
